// File: rtl/risc16_pkg.sv
// Shared RISC16 constants: default fetch widths, reset vector and the major opcode field.
package risc16_pkg;
    localparam int PC_W_DEF     = 8;
    localparam int INSTR_W_DEF  = 16;
    localparam int RESET_PC_DEF = 0;
    localparam int OPC_W        = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_NAND = 4'h2,
        OP_LUI  = 4'h3,
        OP_SW   = 4'h4,
        OP_LW   = 4'h5,
        OP_BEQ  = 4'h6,
        OP_JALR = 4'h7
    } opcode_e;

    function automatic opcode_e opcode_of(input logic [INSTR_W_DEF-1:0] instr);
        return opcode_e'(instr[INSTR_W_DEF-1 -: OPC_W]);
    endfunction
endpackage

// File: rtl/risc16_fetch_if.sv
// Fetch-unit bus: instruction-store read port, redirect input and decode-side handshake.
interface risc16_fetch_if
    import risc16_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               ir_valid;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    ir_pc;
    logic               ir_ready;

    modport master (output imem_req, imem_addr, ir_valid, ir, ir_pc,
                    input  imem_rdata, redirect_valid, redirect_pc, ir_ready);
    modport slave  (input  imem_req, imem_addr, ir_valid, ir, ir_pc,
                    output imem_rdata, redirect_valid, redirect_pc, ir_ready);
endinterface

// File: rtl/risc16_fetch_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with occupancy count and synchronous flush.
module risc16_fetch_fifo
    import risc16_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = PC_W_DEF + INSTR_W_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Flush wins over a same-cycle push so a killed response never lands.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
endmodule

// File: rtl/risc16_fetch.sv
// Instruction fetch: one outstanding read, prefetch FIFO of {word, pc}, redirect flush.
module risc16_fetch
    import risc16_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    risc16_fetch_if.master bus
);
    localparam int ENT_W = INSTR_W + PC_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d, inflight_pc_q;
    logic             inflight_q;
    logic [ENT_W-1:0] head, last_q;
    logic             empty, pop, req;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   committed;

    assign pop = !empty && bus.ir_ready;

    // Slots claimed after this edge if we do not request; a same-cycle pop frees one.
    assign committed = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    assign req       = rst_n_i && !bus.redirect_valid && (committed < (CNT_W+1)'(DEPTH));

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc;
        else if (req)           fetch_pc_d = fetch_pc_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc_q    <= PC_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            last_q        <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= req;
            if (req)    inflight_pc_q <= fetch_pc_q;
            if (!empty) last_q        <= head;
        end
    end

    // The in-flight word lands one cycle after its request; redirect flushes it away.
    risc16_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (bus.redirect_valid),
        .push_i  (inflight_q),
        .wdata_i ({bus.imem_rdata, inflight_pc_q}),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (empty),
        .count_o (count)
    );

    assign bus.imem_req           = req;
    assign bus.imem_addr          = fetch_pc_q;
    assign bus.ir_valid           = !empty;
    assign {bus.ir, bus.ir_pc}    = empty ? last_q : head;
endmodule

// File: tb/tb_risc16_fetch.sv
// Directed and randomized checks of the fetch unit against a one-cycle-latency instruction store.
module tb_risc16_fetch;
    import risc16_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] store [256];
    int          n_chk;
    int          n_fail;

    risc16_fetch_if #(.PC_W(8), .INSTR_W(16)) bus ();

    risc16_fetch #(.PC_W(8), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= store[bus.imem_addr];
        else              bus.imem_rdata <= 16'hBAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ir(input string tag, input logic [7:0] pc);
        chk({tag, "_valid"}, 32'(bus.ir_valid), 32'd1);
        chk({tag, "_pc"},    32'(bus.ir_pc),    32'(pc));
        chk({tag, "_ir"},    32'(bus.ir),       32'(store[pc]));
    endtask

    // Advance to just after the next rising edge, apply inputs, let outputs settle.
    task automatic cyc(input logic rdy, input logic rv, input logic [7:0] rp);
        @(posedge clk);
        #1;
        bus.ir_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        #1;
    endtask

    initial begin
        int          nreq;
        logic [7:0]  exp_pc;
        bit          synced, prev_redir, prev_hold, rdy, rv;
        logic [7:0]  rp;
        logic [23:0] prev_word;

        n_chk = 0;
        n_fail = 0;
        clk = 1'b0;
        rst_n = 1'b1;
        bus.ir_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rdata = '0;
        for (int i = 0; i < 256; i++) store[i] = {8'(i) ^ 8'h5A, 8'(i)};
        store[0] = 16'h2481;
        store[1] = 16'h6400;
        store[2] = 16'hA502;
        store[3] = 16'h0000;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.ir_valid), 32'd0);
        chk("rst_ir",    32'(bus.ir),       32'd0);
        chk("rst_irpc",  32'(bus.ir_pc),    32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);

        // Straight-line fetch from reset with decode always ready
        rst_n = 1'b1;
        #1;
        chk("boot_req",  32'(bus.imem_req),  32'd1);
        chk("boot_addr", 32'(bus.imem_addr), 32'd0);
        chk("boot_v0",   32'(bus.ir_valid),  32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("boot_addr1", 32'(bus.imem_addr), 32'd1);
        chk("boot_v1",    32'(bus.ir_valid),  32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 8'h00);
            chk_ir("boot_seq", 8'(k));
        end

        // Stall until full, then reset with a full buffer
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 8'h00);
            chk_ir("stall_hold", 8'd4);
        end
        chk("full_req", 32'(bus.imem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.ir_valid), 32'd0);
        chk("midrst_req",   32'(bus.imem_req), 32'd0);
        chk("midrst_irpc",  32'(bus.ir_pc),    32'd0);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        // Decode stalled for six cycles after release: exactly DEPTH requests
        rst_n = 1'b1;
        #1;
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc(1'b0, 1'b0, 8'h00);
            nreq += int'(bus.imem_req);
            if (i >= 2) chk_ir("stall6_head", 8'd0);
        end
        chk("stall6_nreq", 32'(nreq), 32'(DEPTH));
        chk("stall6_req_low", 32'(bus.imem_req), 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, 8'h00);
            chk_ir("drain", 8'(k));
        end

        // Redirect with two words buffered and one in flight
        cyc(1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        #1;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h40);
        chk_ir("redir_pre", 8'd0);
        chk("redir_noreq", 32'(bus.imem_req), 32'd0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("redir_v0",   32'(bus.ir_valid),  32'd0);
        chk("redir_req",  32'(bus.imem_req),  32'd1);
        chk("redir_addr", 32'(bus.imem_addr), 32'h40);
        cyc(1'b0, 1'b0, 8'h00);
        chk("redir_v1", 32'(bus.ir_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk_ir("redir_first", 8'h40);
        cyc(1'b1, 1'b0, 8'h00);
        chk_ir("redir_next", 8'h41);

        // Redirect coincident with a handshake, target wraps past 0xFF
        cyc(1'b1, 1'b1, 8'hFE);
        chk_ir("wrap_hs", 8'h42);
        cyc(1'b1, 1'b0, 8'h00);
        chk("wrap_v0",   32'(bus.ir_valid),  32'd0);
        chk("wrap_addr", 32'(bus.imem_addr), 32'hFE);
        cyc(1'b1, 1'b0, 8'h00);
        chk("wrap_addr1", 32'(bus.imem_addr), 32'hFF);
        cyc(1'b1, 1'b0, 8'h00);
        chk("wrap_addr2", 32'(bus.imem_addr), 32'h00);
        chk_ir("wrap_seq0", 8'hFE);
        cyc(1'b1, 1'b0, 8'h00);
        chk_ir("wrap_seq1", 8'hFF);
        cyc(1'b1, 1'b0, 8'h00);
        chk_ir("wrap_seq2", 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk_ir("wrap_seq3", 8'h01);

        // Back-to-back redirects: last target wins
        cyc(1'b1, 1'b1, 8'h10);
        cyc(1'b1, 1'b1, 8'h20);
        chk("b2b_v0",  32'(bus.ir_valid), 32'd0);
        chk("b2b_req", 32'(bus.imem_req), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("b2b_addr", 32'(bus.imem_addr), 32'h20);
        chk("b2b_v1",   32'(bus.ir_valid),  32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("b2b_v2", 32'(bus.ir_valid), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk_ir("b2b_first", 8'h20);
        cyc(1'b1, 1'b0, 8'h00);
        chk_ir("b2b_next", 8'h21);

        // Random ready and redirects with a pc-sequence scoreboard
        exp_pc = '0;
        synced = 1'b0;
        prev_redir = 1'b0;
        prev_hold = 1'b0;
        prev_word = '0;
        for (int i = 0; i < 10000; i++) begin
            rdy = ($urandom_range(0, 1) == 1);
            rv  = (i == 0) || ($urandom_range(0, 31) == 0);
            rp  = 8'($urandom_range(0, 255));
            cyc(rdy, rv, rp);
            if (prev_redir) chk("rnd_flush", 32'(bus.ir_valid), 32'd0);
            if (prev_hold) begin
                chk("rnd_hold_v", 32'(bus.ir_valid), 32'd1);
                chk("rnd_hold_w", 32'({bus.ir, bus.ir_pc}), 32'(prev_word));
            end
            if (rv) chk("rnd_redir_noreq", 32'(bus.imem_req), 32'd0);
            if (bus.ir_valid && rdy) begin
                chk("rnd_word", 32'(bus.ir), 32'(store[bus.ir_pc]));
                if (synced) chk("rnd_pc", 32'(bus.ir_pc), 32'(exp_pc));
                exp_pc = bus.ir_pc + 8'd1;
            end
            if (rv) begin
                exp_pc = rp;
                synced = 1'b1;
            end
            prev_redir = rv;
            prev_hold  = bus.ir_valid && !rdy && !rv;
            prev_word  = {bus.ir, bus.ir_pc};
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/risc16_fetch.md
RISC16_FETCH -- requirements
Module: risc16_fetch

Interface
REQ-001 Parameter PC_W, default 8, instruction address width; 256-word instruction store.
REQ-002 Parameter INSTR_W, default 16, instruction word width.
REQ-003 Parameter DEPTH, default 2, prefetch buffer entries; legal values 2 or 4.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 imem_req  output  1  read request to instruction store this cycle.
REQ-008 imem_addr  output  PC_W  word address of the request.
REQ-009 imem_rdata  input  INSTR_W  read data, valid exactly one cycle after the accepted request.
REQ-010 redirect_valid  input  1  discard all prefetched/in-flight words and restart fetch.
REQ-011 redirect_pc  input  PC_W  restart address, sampled when redirect_valid=1.
REQ-012 ir_valid  output  1  buffer head holds a valid instruction.
REQ-013 ir  output  INSTR_W  head instruction word.
REQ-014 ir_pc  output  PC_W  address the head word was fetched from.
REQ-015 ir_ready  input  1  decode stage accepts head; transfer occurs when ir_valid & ir_ready.

Function
REQ-016 Block SHALL hold fetch_pc, a DEPTH-entry FIFO of {word, pc}, and an inflight flag for the one outstanding read.
REQ-017 imem_req SHALL assert when (occupancy + inflight) < DEPTH, or when a pop in the same cycle frees a slot; never when redirect_valid=1.
REQ-018 When imem_req=1: imem_addr=fetch_pc; fetch_pc increments by 1 at next edge, modulo 2^PC_W (255 -> 0).
REQ-019 Returning word SHALL be written to the FIFO tail with its pc one cycle after the request, unless killed by a redirect.
REQ-020 Fetch-to-ir_valid latency: 2 cycles from the request edge (request cycle N, data cycle N+1, ir_valid cycle N+2).
REQ-021 With ir_ready held 1 and no redirect, throughput SHALL be one instruction per cycle in steady state.
REQ-022 ir/ir_pc SHALL remain stable while ir_valid=1 and ir_ready=0.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; a pop on a full buffer permits a push in the same cycle.
REQ-024 Empty: ir_valid=0, ir/ir_pc hold their last value. Full with no free slot: imem_req=0.
REQ-025 Redirect: at the edge where redirect_valid=1, FIFO is emptied, inflight response is dropped, fetch_pc loads redirect_pc; ir_valid=0 in the following cycle; first request to redirect_pc is issued in the following cycle.
REQ-026 Redirect coincident with a valid handshake: the handshake completes (head consumed), then the flush applies.
REQ-027 Back-to-back redirects: the last redirect_pc wins; no word from an earlier target is ever presented.

Reset
REQ-028 On rst_n=0 (asynchronous): fetch_pc=RESET_PC, FIFO empty, inflight=0, imem_req=0, ir_valid=0, ir=0, ir_pc=0.
REQ-029 First imem_req SHALL assert in the first cycle after rst_n deasserts, with imem_addr=RESET_PC.
REQ-030 Reset mid-operation SHALL discard all buffered and in-flight words; no stale word appears after release.

Structure
REQ-031 PC_W, INSTR_W, RESET_PC defaults and opcode constants SHALL reside in shared package risc16_pkg.
REQ-032 FIFO storage and pointers SHALL be a sub-module risc16_fetch_fifo (DEPTH, width PC_W+INSTR_W, synchronous flush input).
REQ-033 Block SHALL contain no combinational path from imem_rdata to ir/ir_valid.

Verification
REQ-034 Reset release, ir_ready=1, store[0..3]=0x2481,0x6400,0xA502,0x0000 -> ir sequence 0x2481,0x6400,0xA502,0x0000 with ir_pc 0,1,2,3; first ir_valid 2 cycles after first request.
REQ-035 ir_ready=0 for 6 cycles -> exactly DEPTH requests issued, imem_req then low, ir=store[0] stable; ir_ready=1 -> words 0..5 in order, no gap, no duplicate.
REQ-036 Redirect to 0x40 while 2 words buffered and 1 in flight -> ir_valid=0 next cycle, next presented word is store[0x40] with ir_pc=0x40; none of the discarded words appear.
REQ-037 redirect_pc=0xFE, ir_ready=1 -> ir_pc sequence 0xFE,0xFF,0x00,0x01.
REQ-038 rst_n pulsed low mid-stream with buffer full -> ir_valid=0 immediately; after release first ir_pc=RESET_PC.
REQ-039 Random ir_ready (50%) plus random redirects over 10k cycles -> scoreboard: every presented {ir,ir_pc} equals store[ir_pc], pcs consecutive between redirects.
